// File: rtl/tap_tempo.sv
// Tap-tempo estimator: times the interval between tap rising edges and
// converts it to a clamped 10-bit BPM using a 32-cycle restoring divider.
// Latency: accepted tap edge at cycle t -> update_o pulse at cycle t+34.
module tap_tempo #(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned MIN_BPM = 20,
   parameter int unsigned MAX_BPM = 511
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tap_i,
   output logic [9:0] bpm_o,
   output logic       valid_o,
   output logic       update_o,
   output logic       armed_o
);

   // Numerator is cycles per minute; computed wide so CLK_HZ*60 cannot wrap
   localparam logic [63:0] NUM_W = 64'(CLK_HZ) * 64'd60;
   localparam logic [31:0] NUM   = NUM_W[31:0];
   localparam logic [31:0] TMO   = NUM / MIN_BPM;
   localparam logic [31:0] MINI  = NUM / MAX_BPM;
   localparam logic [31:0] MINB  = MIN_BPM;
   localparam logic [31:0] MAXB  = MAX_BPM;

   typedef enum logic {
      ST_IDLE,
      ST_ARMED
   } st_e;

   typedef enum logic [1:0] {
      DV_IDLE,
      DV_RUN,
      DV_DONE
   } dv_e;

   // Edge detection and interval measurement state
   logic        tap_q;
   st_e         st_q, st_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] hist_q [4];
   logic [31:0] hist_d [4];
   logic [2:0]  hcnt_q, hcnt_d;
   logic        pend_q, pend_d;

   // Divider and output state
   dv_e         dv_q, dv_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [4:0]  iter_q, iter_d;
   logic [9:0]  bpm_q, bpm_d;
   logic        valid_q, valid_d;
   logic        update_q, update_d;

   logic        edge_w;
   logic        accept_w;
   logic        start_w;
   logic [33:0] sum_w;
   logic [31:0] div_w;
   logic [32:0] rem_sh_w;
   logic [32:0] diff_w;

   function automatic logic [9:0] clamp_bpm(input logic [31:0] q);
      logic [31:0] r;
      if (q < MINB)
         r = MINB;
      else if (q > MAXB)
         r = MAXB;
      else
         r = q;
      return r[9:0];
   endfunction

   assign edge_w   = tap_i & ~tap_q;
   // Intervals shorter than MINI are bounce/glitches: counter and history untouched
   assign accept_w = edge_w && (st_q == ST_ARMED) && (cnt_q >= MINI);
   // A queued divide launches the cycle after the previous result is published
   assign start_w  = (dv_q == DV_IDLE) && (accept_w || pend_q);

   // Tap FSM next state: arming, interval counting, history push and timeout
   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      hcnt_d = hcnt_q;
      for (int i = 0; i < 4; i++)
         hist_d[i] = hist_q[i];

      case (st_q)
         ST_IDLE: begin
            if (edge_w) begin
               st_d  = ST_ARMED;
               cnt_d = 32'd1;
            end
         end
         ST_ARMED: begin
            if (accept_w) begin
               cnt_d     = 32'd1;
               hist_d[0] = cnt_q;
               hist_d[1] = hist_q[0];
               hist_d[2] = hist_q[1];
               hist_d[3] = hist_q[2];
               hcnt_d    = (hcnt_q == 3'd4) ? 3'd4 : 3'(hcnt_q + 3'd1);
            end else if (cnt_q == TMO) begin
               // Timeout: forget the tempo history but keep the last BPM on the output
               st_d   = ST_IDLE;
               cnt_d  = '0;
               hcnt_d = '0;
            end else begin
               cnt_d = 32'(cnt_q + 32'd1);
            end
         end
         default: begin
            st_d  = ST_IDLE;
            cnt_d = '0;
         end
      endcase
   end

   // Divisor from the post-push history so a same-cycle edge is included
   always_comb begin
      sum_w = {2'b00, hist_d[0]} + {2'b00, hist_d[1]}
            + {2'b00, hist_d[2]} + {2'b00, hist_d[3]};
      div_w = (hcnt_d == 3'd4) ? 32'(sum_w >> 2) : hist_d[0];
   end

   // Pending flag: at most one extra divide is remembered while the divider is busy
   always_comb begin
      pend_d = pend_q;
      if (start_w)
         pend_d = 1'b0;
      else if (accept_w)
         pend_d = 1'b1;
   end

   // Divider FSM next state: load, 32 restoring iterations, then publish the clamped result
   always_comb begin
      dv_d     = dv_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      iter_d   = iter_q;
      bpm_d    = bpm_q;
      valid_d  = valid_q;
      update_d = 1'b0;
      rem_sh_w = {rem_q, quo_q[31]};
      diff_w   = rem_sh_w - {1'b0, dvs_q};

      case (dv_q)
         DV_IDLE: begin
            if (start_w) begin
               dv_d   = DV_RUN;
               dvs_d  = div_w;
               rem_d  = '0;
               quo_d  = NUM;
               iter_d = '0;
            end
         end
         DV_RUN: begin
            // Quotient bits shift in from the right as numerator bits shift out the left
            if (rem_sh_w >= {1'b0, dvs_q}) begin
               rem_d = 32'(diff_w);
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = 32'(rem_sh_w);
               quo_d = {quo_q[30:0], 1'b0};
            end
            iter_d = 5'(iter_q + 5'd1);
            if (iter_q == 5'd31)
               dv_d = DV_DONE;
         end
         DV_DONE: begin
            bpm_d    = clamp_bpm(quo_q);
            valid_d  = 1'b1;
            update_d = 1'b1;
            dv_d     = DV_IDLE;
         end
         default: begin
            dv_d = DV_IDLE;
         end
      endcase
   end

   // Tap FSM registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tap_q  <= 1'b0;
         st_q   <= ST_IDLE;
         cnt_q  <= '0;
         hcnt_q <= '0;
         pend_q <= 1'b0;
         for (int i = 0; i < 4; i++)
            hist_q[i] <= '0;
      end else begin
         tap_q  <= tap_i;
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         hcnt_q <= hcnt_d;
         pend_q <= pend_d;
         for (int i = 0; i < 4; i++)
            hist_q[i] <= hist_d[i];
      end
   end

   // Divider and output registers; reset aborts any divide in flight
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dv_q     <= DV_IDLE;
         dvs_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         iter_q   <= '0;
         bpm_q    <= '0;
         valid_q  <= 1'b0;
         update_q <= 1'b0;
      end else begin
         dv_q     <= dv_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         iter_q   <= iter_d;
         bpm_q    <= bpm_d;
         valid_q  <= valid_d;
         update_q <= update_d;
      end
   end

   assign bpm_o    = bpm_q;
   assign valid_o  = valid_q;
   assign update_o = update_q;
   assign armed_o  = (st_q == ST_ARMED);

endmodule

// File: tb/tb_tap_tempo.sv
// Bench for tap_tempo: table of tap intervals with hand-computed BPM results,
// plus directed sequences for timeout, glitch, held tap, queued divide and reset abort.
// Main instance uses CLK_HZ=1000 (N=60000, MINI=117, TMO=3000).
module tb_tap_tempo;

   logic       clk = 1'b0;
   logic       rst, tap, valid, update, armed;
   logic [9:0] bpm;
   logic       rst2, tap2, valid2, update2, armed2;
   logic [9:0] bpm2;

   int errors  = 0;
   int checks  = 0;
   int since   = 0;
   int upd_cnt = 0;
   int upd2_cnt = 0;

   always #5 clk = ~clk;

   tap_tempo #(.CLK_HZ(1000), .MIN_BPM(20), .MAX_BPM(511)) dut (
      .clk_i(clk), .rst_i(rst), .tap_i(tap),
      .bpm_o(bpm), .valid_o(valid), .update_o(update), .armed_o(armed)
   );

   // Second instance: N=6000, MINI=6, so an accepted edge can land inside a running divide
   tap_tempo #(.CLK_HZ(100), .MIN_BPM(20), .MAX_BPM(1000)) dut2 (
      .clk_i(clk), .rst_i(rst2), .tap_i(tap2),
      .bpm_o(bpm2), .valid_o(valid2), .update_o(update2), .armed_o(armed2)
   );

   always @(posedge clk) begin
      if (update)  upd_cnt  <= upd_cnt + 1;
      if (update2) upd2_cnt <= upd2_cnt + 1;
   end

   typedef struct {
      bit do_rst;
      int gap;
      int exp_bpm;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      since++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tap = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One-cycle tap; afterwards since==1, equal to the DUT interval counter
   task automatic pulse();
      tap = 1'b1;
      tick();
      tap = 1'b0;
      since = 1;
   endtask

   task automatic tap_after(input int gap);
      while (since < gap) tick();
      pulse();
   endtask

   // since counts cycles from the edge, so the update should appear at since==34
   task automatic wait_upd(input string name, input int exp_bpm);
      while (!update && since < 200) tick();
      chk({name, " latency"}, since, 34);
      chk({name, " bpm"}, int'(bpm), exp_bpm);
      chk({name, " valid"}, int'(valid), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int u0;
      int k;

      vecs[0] = '{1'b1,  500, 120};
      vecs[1] = '{1'b0,  600, 100};
      vecs[2] = '{1'b0,  500, 120};
      vecs[3] = '{1'b0,  400, 120};
      vecs[4] = '{1'b0,  800, 104};
      vecs[5] = '{1'b1,  117, 511};
      vecs[6] = '{1'b0, 2999,  20};

      rst  = 1'b1;
      tap  = 1'b0;
      rst2 = 1'b1;
      tap2 = 1'b0;
      tick();
      tick();
      rst  = 1'b0;
      rst2 = 1'b0;

      chk("reset bpm",    int'(bpm),    0);
      chk("reset valid",  int'(valid),  0);
      chk("reset update", int'(update), 0);
      chk("reset armed",  int'(armed),  0);

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].do_rst) begin
            do_reset();
            pulse();
            chk($sformatf("v%0d armed", i), int'(armed), 1);
         end
         tap_after(vecs[i].gap);
         wait_upd($sformatf("v%0d", i), vecs[i].exp_bpm);
      end

      // Timeout from the last accepted tap: armed through Cnt==3000, dropped after
      while (since < 3000) tick();
      chk("tmo armed at 3000", int'(armed), 1);
      tick();
      chk("tmo armed after", int'(armed), 0);
      chk("tmo bpm held", int'(bpm), 20);
      chk("tmo valid held", int'(valid), 1);
      u0 = upd_cnt;
      pulse();
      repeat (40) tick();
      chk("rearm armed", int'(armed), 1);
      chk("rearm no update", upd_cnt - u0, 0);

      // Reset in the middle of a divide: outputs cleared, result discarded
      tap_after(500);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort bpm", int'(bpm), 0);
      chk("abort valid", int'(valid), 0);
      chk("abort armed", int'(armed), 0);
      u0 = upd_cnt;
      repeat (60) tick();
      chk("abort no update", upd_cnt - u0, 0);

      // Tap held high yields a single edge
      do_reset();
      u0 = upd_cnt;
      tap = 1'b1;
      tick();
      since = 1;
      while (since < 600) tick();
      chk("hold armed", int'(armed), 1);
      chk("hold no update", upd_cnt - u0, 0);
      tap = 1'b0;
      tap_after(700);
      wait_upd("hold", 85);

      // Glitch at 60 cycles is ignored; next interval is measured from the accepted tap
      do_reset();
      pulse();
      tap_after(500);
      wait_upd("pre glitch", 120);
      while (since < 60) tick();
      tap = 1'b1;
      tick();
      tap = 1'b0;
      u0 = upd_cnt;
      tap_after(500);
      chk("glitch no update", upd_cnt - u0, 0);
      wait_upd("post glitch", 120);

      // Queued divide on dut2: edges at B+10 and B+20 give exactly one extra divide
      tap2 = 1'b1;
      tick();
      tap2 = 1'b0;
      repeat (199) tick();
      tap2 = 1'b1;
      tick();
      tap2 = 1'b0;
      k = 1;
      while (k < 10) begin tick(); k++; end
      tap2 = 1'b1;
      tick();
      tap2 = 1'b0;
      k++;
      while (k < 20) begin tick(); k++; end
      tap2 = 1'b1;
      tick();
      tap2 = 1'b0;
      k++;
      while (!update2 && k < 100) begin tick(); k++; end
      chk("pend first latency", k, 34);
      chk("pend first bpm", int'(bpm2), 30);
      tick();
      k++;
      while (!update2 && k < 150) begin tick(); k++; end
      chk("pend second latency", k, 68);
      chk("pend second bpm", int'(bpm2), 600);
      repeat (80) tick();
      chk("pend update count", upd2_cnt, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
